// File: rtl/echo_capture.sv
// echo_capture: measures the high time of an asynchronous echo line in
// prescaled ticks, with a timeout in both the waiting and measuring phases.
// Optional glitch filter after the synchronizer: define ECHO_FILTER_EN.
module echo_capture #(
  parameter int CNT_W   = 16,
  parameter int DIV     = 50,
  parameter int TIMEOUT = 40000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             echo,
  output logic [CNT_W-1:0] width,
  output logic             valid,
  output logic             busy,
  output logic             tmo
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic             syncMeta_q;
  logic             syncEcho_q;
  logic             echoClean;
  logic             prev_q;
  logic             rise_q;
  logic             fall_q;

  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] res_q;
  logic             tmoFlag_q;
  logic [CNT_W-1:0] width_q;
  logic             valid_q;
  logic             busy_q;
  logic             tmo_q;
  logic             tick;
  logic             tmoHit;

  // Two-flop synchronizer bringing the raw echo into the clk domain.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      syncMeta_q <= 1'b0;
      syncEcho_q <= 1'b0;
    end else begin
      syncMeta_q <= echo;
      syncEcho_q <= syncMeta_q;
    end
  end

`ifdef ECHO_FILTER_EN
  logic [1:0] hist_q;

  // History of the two previous synchronized samples used by the filter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= {hist_q[0], syncEcho_q};
    end
  end

  // The clean echo follows sync_echo only after three identical samples, otherwise holds.
  always_comb begin
    echoClean = prev_q;
    if ((syncEcho_q == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
      echoClean = syncEcho_q;
    end
  end
`else
  assign echoClean = syncEcho_q;
`endif

  // Registered edge detection; the held copy also serves as the filter state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= echoClean;
      rise_q <= echoClean & ~prev_q;
      fall_q <= ~echoClean & prev_q;
    end
  end

  assign tick   = (presc_q == PRESC_MAX);
  assign tmoHit = tick && ((cnt_q + CNT_W'(1)) == CNT_LIMIT);

  // Next values of the prescaler and tick counter while time is running.
  always_comb begin
    presc_d = presc_q + PW'(1);
    cnt_d   = cnt_q;
    if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Measurement FSM with registered result, strobe and busy outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      tmoFlag_q <= 1'b0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARMED;
            presc_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (rise_q) begin
            state_q <= MEASURE;
            presc_q <= '0;
            cnt_q   <= '0;
          end else if (tmoHit) begin
            state_q   <= DONE;
            res_q     <= '1;
            tmoFlag_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
          end
        end
        MEASURE: begin
          if (tmoHit) begin
            state_q   <= DONE;
            res_q     <= '1;
            tmoFlag_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (fall_q) begin
            state_q   <= DONE;
            res_q     <= cnt_d;
            tmoFlag_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
          end
        end
        DONE: begin
          width_q <= res_q;
          tmo_q   <= tmoFlag_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign width = width_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign tmo   = tmo_q;

endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: self-checking bench for echo_capture with DIV=4, CNT_W=8,
// TIMEOUT=200. Expected widths come from floor(high cycles / DIV).
module tb_echo_capture;

  localparam int CNT_W   = 8;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 200;
  localparam int TMO_CYC = DIV * TIMEOUT;
`ifdef ECHO_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             echo;
  logic [CNT_W-1:0] width;
  logic             valid;
  logic             busy;
  logic             tmo;

  int checks     = 0;
  int passed     = 0;
  int validCount = 0;

  echo_capture #(
    .CNT_W  (CNT_W),
    .DIV    (DIV),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .echo (echo),
    .width(width),
    .valid(valid),
    .busy (busy),
    .tmo  (tmo)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Counts valid strobes, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) validCount++;
  end

  // Reference: completed ticks for an echo held high n cycles, or all ones on timeout.
  function automatic logic [CNT_W-1:0] expWidth(input int n);
    int t;
    t = n / DIV;
    if (t >= TIMEOUT) return '1;
    return CNT_W'(t);
  endfunction

  // One-cycle start pulse, driven at a negedge.
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds echo high len cycles, then reports negedges until valid (0 if none).
  task automatic runPulse(input int len, output int lat);
    echo = 1'b1;
    repeat (len) @(negedge clk);
    echo = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Waits for valid up to a bound; returns negedges elapsed (0 if none).
  task automatic waitValid(input int bound, output int k);
    k = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (width !== '0) $display("FAIL reset_width: got %0h expected 0", width); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (tmo !== 1'b0) $display("FAIL reset_tmo: got %b expected 0", tmo); else passed++;
    clr = 1'b0;
    pulseStart();
    checks++; if (busy !== 1'b1) $display("FAIL start_after_reset: got busy %b expected 1", busy); else passed++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reclear_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_nominal();
    int lat;
    int vc0;
    vc0 = validCount;
    pulseStart();
    checks++; if (busy !== 1'b1) $display("FAIL busy_armed: got %b expected 1", busy); else passed++;
    repeat (9) @(negedge clk);
    runPulse(40, lat);
    checks++; if (lat != LAT + 1) $display("FAIL latency: got %0d cycles expected %0d", lat - 1, LAT); else passed++;
    checks++; if (width !== expWidth(40)) $display("FAIL nominal_width: got %0d expected %0d", width, expWidth(40)); else passed++;
    checks++; if (tmo !== 1'b0) $display("FAIL nominal_tmo: got %b expected 0", tmo); else passed++;
    @(negedge clk);
    checks++; if (valid !== 1'b0) $display("FAIL valid_one_cycle: got %b expected 0", valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_after_valid: got %b expected 0", busy); else passed++;
    repeat (5) @(negedge clk);
    #2;
    checks++; if (validCount - vc0 != 1) $display("FAIL nominal_strobes: got %0d expected 1", validCount - vc0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_no_echo();
    int k;
    start = 1'b1;
    waitValid(TMO_CYC + 100, k);
    checks++; if (k < TMO_CYC || k > TMO_CYC + 10) $display("FAIL noecho_time: got %0d cycles expected %0d..%0d", k, TMO_CYC, TMO_CYC + 10); else passed++;
    checks++; if (width !== '1) $display("FAIL noecho_width: got %0h expected ff", width); else passed++;
    checks++; if (tmo !== 1'b1) $display("FAIL noecho_tmo: got %b expected 1", tmo); else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stuck_high();
    int k;
    pulseStart();
    repeat (4) @(negedge clk);
    echo = 1'b1;
    waitValid(TMO_CYC + 100, k);
    checks++; if (k < TMO_CYC || k > TMO_CYC + 12) $display("FAIL stuck_time: got %0d cycles expected %0d..%0d", k, TMO_CYC, TMO_CYC + 12); else passed++;
    checks++; if (width !== '1) $display("FAIL stuck_width: got %0h expected ff", width); else passed++;
    checks++; if (tmo !== 1'b1) $display("FAIL stuck_tmo: got %b expected 1", tmo); else passed++;
    echo = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_busy_guard();
    int vc0;
    vc0 = validCount;
    pulseStart();
    repeat (9) @(negedge clk);
    echo = 1'b1;
    repeat (23) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL busy_measure: got %b expected 1", busy); else passed++;
    pulseStart();
    repeat (16) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    checks++; if (validCount - vc0 != 1) $display("FAIL guard_strobes: got %0d expected 1", validCount - vc0); else passed++;
    checks++; if (width !== expWidth(40)) $display("FAIL guard_width: got %0d expected %0d", width, expWidth(40)); else passed++;
    checks++; if (tmo !== 1'b0) $display("FAIL guard_tmo: got %b expected 0", tmo); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int vc0;
    int lat;
    vc0 = validCount;
    pulseStart();
    repeat (9) @(negedge clk);
    echo = 1'b1;
    repeat (20) @(negedge clk);
    clr = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy_async: got %b expected 0", busy); else passed++;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (width !== '0) $display("FAIL abort_width: got %0d expected 0", width); else passed++;
    repeat (19) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    checks++; if (validCount != vc0) $display("FAIL abort_no_valid: got %0d strobes expected 0", validCount - vc0); else passed++;
    @(negedge clk);
    pulseStart();
    repeat (5) @(negedge clk);
    runPulse(12, lat);
    checks++; if (lat == 0) $display("FAIL abort_rerun_valid: got none expected one"); else passed++;
    checks++; if (width !== expWidth(12)) $display("FAIL abort_rerun_width: got %0d expected %0d", width, expWidth(12)); else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch();
    int lat;
    pulseStart();
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (2) @(negedge clk);
    echo = 1'b0;
`ifdef ECHO_FILTER_EN
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL glitch_still_armed: got %b expected 1", busy); else passed++;
    runPulse(40, lat);
    checks++; if (lat == 0) $display("FAIL glitch_valid: got none expected one"); else passed++;
    checks++; if (width !== expWidth(40)) $display("FAIL glitch_width: got %0d expected %0d", width, expWidth(40)); else passed++;
`else
    waitValid(30, lat);
    checks++; if (lat == 0) $display("FAIL glitch_valid: got none expected one"); else passed++;
    checks++; if (width !== expWidth(2)) $display("FAIL glitch_width: got %0d expected %0d", width, expWidth(2)); else passed++;
`endif
    checks++; if (tmo !== 1'b0) $display("FAIL glitch_tmo: got %b expected 0", tmo); else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    int gap;
    int lat;
    for (int i = 0; i < 10; i++) begin
      len = int'($urandom_range(3, 150));
      gap = int'($urandom_range(1, 20));
      pulseStart();
      repeat (gap) @(negedge clk);
      runPulse(len, lat);
      checks++; if (lat != LAT + 1) $display("FAIL rand_latency len=%0d: got %0d expected %0d", len, lat - 1, LAT); else passed++;
      checks++; if (width !== expWidth(len)) $display("FAIL rand_width len=%0d: got %0d expected %0d", len, width, expWidth(len)); else passed++;
      checks++; if (tmo !== 1'b0) $display("FAIL rand_tmo len=%0d: got %b expected 0", len, tmo); else passed++;
      repeat (int'($urandom_range(2, 6))) @(negedge clk);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    clr = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    test_reset();
    test_nominal();
    test_no_echo();
    test_stuck_high();
    test_busy_guard();
    test_reset_abort();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/echo_capture.md
ECHO_CAPTURE -- requirements
Module: echo_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the measured pulse-width result in bits.
REQ-002 Parameter DIV, default 50: clk cycles per measurement tick; legal range 1 to 65535.
REQ-003 Parameter TIMEOUT, default 40000: maximum ticks allowed in ARMED and in MEASURE; legal range 1 to 2^CNT_W-2.
REQ-004 clk  input  1  system clock; all state changes on posedge.
REQ-005 clr  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  arm request, sampled one cycle high; normally the trigger-generator output.
REQ-007 echo  input  1  asynchronous echo line from the sensor; high for the time-of-flight.
REQ-008 width  output  CNT_W  last measured echo width in ticks; all ones on timeout.
REQ-009 valid  output  1  one-cycle strobe; width and tmo are updated in the same cycle.
REQ-010 busy  output  1  high in ARMED and in MEASURE.
REQ-011 tmo  output  1  high when the last measurement timed out; updated with valid.

Function
REQ-012 echo shall pass through a two-flop synchronizer before any use; sync_echo is the second flop.
REQ-013 Edges shall be detected against a registered copy of sync_echo: rise = sync_echo & ~prev, fall = ~sync_echo & prev.
REQ-014 The FSM shall have the states IDLE, ARMED, MEASURE and DONE, encoded as 2 bits.
REQ-015 IDLE: start=1 moves to ARMED and clears the tick counter and the prescaler; otherwise the FSM stays in IDLE.
REQ-016 ARMED: rise moves to MEASURE with the tick counter and prescaler cleared.
REQ-017 ARMED: the counter reaching TIMEOUT ticks with no rise moves to DONE with the timeout flag set.
REQ-018 MEASURE: the prescaler counts 0..DIV-1; when it wraps, it emits a tick that increments the tick counter.
REQ-019 MEASURE: fall moves to DONE with the result equal to the tick counter (number of completed ticks).
REQ-020 MEASURE: the tick counter reaching TIMEOUT moves to DONE with the timeout flag set and the result forced to all ones.
REQ-021 DONE lasts exactly one cycle: width and tmo are loaded, valid=1, then the FSM returns to IDLE.
REQ-022 Latency: valid shall assert exactly 4 clk cycles after the first clk edge at which the raw echo is sampled low. Breakdown: 2 synchronizer cycles, 1 edge-detect cycle, 1 DONE cycle.
REQ-023 start while busy=1 or in DONE shall be ignored; it is not queued.
REQ-024 A rise and start in the same cycle in IDLE: start is taken and the rise is ignored. The measurement waits for the next rise.
REQ-025 echo already high when ARMED is entered: no rise occurs, so the FSM waits for a fresh rise or for the timeout.
REQ-026 width and tmo shall hold their values between valid strobes.
REQ-027 DIV=1 shall give a tick every cycle in MEASURE.

Reset
REQ-028 clr=1 shall immediately force: FSM=IDLE, width=0, valid=0, busy=0, tmo=0, counters=0, synchronizer and edge flops=0.
REQ-029 clr asserted mid-measurement shall abort the measurement with no valid strobe.
REQ-030 After clr deasserts, the first start shall be accepted on the first clk edge.

Configuration
REQ-031 Macro ECHO_FILTER_EN, when defined, shall insert a majority-free glitch filter after the synchronizer. The filtered echo changes only after 3 consecutive identical sync_echo samples.
REQ-032 With ECHO_FILTER_EN, pulses of 2 cycles or less are invisible, and REQ-022 latency becomes 6 cycles.
REQ-033 Without ECHO_FILTER_EN, sync_echo drives edge detection directly; there is no filter logic and no extra latency.

Verification
Bench parameters: DIV=4, CNT_W=8, TIMEOUT=200.
REQ-034 Nominal: start pulse; echo high for 40 cycles after 10 cycles -> one valid, width=10, tmo=0, busy low after valid.
REQ-035 No echo: start; echo held low -> valid 800 cycles (+3) after ARMED entry, width=0xFF, tmo=1.
REQ-036 Stuck-high echo: start; rise after 5 cycles, echo never falls -> valid after 200 ticks, width=0xFF, tmo=1.
REQ-037 Busy guard: second start pulse 20 cycles into MEASURE; echo 40 cycles -> exactly one valid, width=10.
REQ-038 Reset abort: clr pulsed at cycle 20 of a 40-cycle echo -> no valid, width=0, busy=0; a following start plus a 12-cycle echo gives width=3.
REQ-039 Filter (ECHO_FILTER_EN defined): 2-cycle echo glitch, then a 40-cycle echo -> width=10 from the second pulse. Without the macro, the glitch gives width=0, tmo=0.
